// File: rtl/fu_wb_pkg.sv
// Shared types for the FU writeback buffer: the writeback payload carried
// from a functional unit to the PRF write port and ROB finish interface.
package fu_wb_pkg;

    localparam int PRF_ADDR_W = 6;
    localparam int ROB_ID_W   = 6;
    localparam int EXC_W      = 5;

    typedef struct packed {
        logic                  prf_wen;
        logic [PRF_ADDR_W-1:0] prf_waddr;
        logic [31:0]           prf_wdata;
        logic                  set_finish;
        logic [ROB_ID_W-1:0]   rob_id;
        logic                  set_branch_status;
        logic                  branch_taken;
        logic [31:0]           branch_addr;
        logic                  set_exception;
        logic [EXC_W-1:0]      exception_type;
        logic [31:0]           bad_vaddr;
    } fu_wb_t;

endpackage

// File: rtl/fu_wb_fifo.sv
// One writeback channel: DEPTH-entry FIFO with registered-count ready,
// explicit pointer wrap (any DEPTH) and zero-masked head output.
module fu_wb_fifo
    import fu_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  fu_wb_t           in_data,
    output logic             in_ready,
    output logic             out_valid,
    output fu_wb_t           out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy
);

    fu_wb_t           storage_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             enq, deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends only on the registered count, never on out_ready.
    assign in_ready  = (count_reg < CNT_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign out_data  = out_valid ? storage_reg[rd_ptr_reg] : '0;
    assign occupancy = count_reg;

    assign enq = in_valid & in_ready & ~flush;
    assign deq = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (enq) wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (deq) rd_ptr_next = ptr_inc(rd_ptr_reg);
            if (enq && !deq)      count_next = count_reg + CNT_W'(1);
            else if (deq && !enq) count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) storage_reg[i] <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (enq) storage_reg[wr_ptr_reg] <= in_data;
        end
    end

endmodule

// File: rtl/fu_wb_buffer.sv
// Multi-channel FU writeback buffer: NUM_CH independent FIFOs sharing
// clock, reset and flush, with per-channel valid/ready on both sides.
module fu_wb_buffer
    import fu_wb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic   [NUM_CH-1:0]            in_valid,
    input  fu_wb_t [NUM_CH-1:0]            in_data,
    output logic   [NUM_CH-1:0]            in_ready,
    output logic   [NUM_CH-1:0]            out_valid,
    output fu_wb_t [NUM_CH-1:0]            out_data,
    input  logic   [NUM_CH-1:0]            out_ready,
    output logic   [NUM_CH-1:0][CNT_W-1:0] occupancy
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            fu_wb_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .in_valid  (in_valid[gi]),
                .in_data   (in_data[gi]),
                .in_ready  (in_ready[gi]),
                .out_valid (out_valid[gi]),
                .out_data  (out_data[gi]),
                .out_ready (out_ready[gi]),
                .occupancy (occupancy[gi])
            );
        end
    endgenerate

endmodule
